// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and default geometry.
package seq_add_sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple adder. Also exports the carry into the top
// bit so the caller can derive signed overflow on the last digit.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Bit-by-bit ripple: sum and majority carry for each position.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor. Operands are latched on start, then one
// DIGIT-wide slice is added per cycle, least significant first. The A
// register doubles as the result accumulator: as A shifts right, each result
// digit enters at the top, so after NDIG cycles it holds the full sum.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, a_nxt, b_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] dsum;
  logic             dco, dcmsb;

  add_digit #(.DIGIT(DIGIT)) u_dig (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .ci   (carry),
    .s    (dsum),
    .co   (dco),
    .c_msb(dcmsb)
  );

  // Shift networks; a single-digit configuration has nothing to shift.
  generate
    if (NDIG == 1) begin : g_one
      assign a_nxt = dsum;
      assign b_nxt = b_sh;
    end else begin : g_multi
      assign a_nxt = {dsum, a_sh[WIDTH-1:DIGIT]};
      assign b_nxt = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last = (cnt == CW'(NDIG - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only looked at while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == ST_RUN);
  end

  // Datapath: latch conditioned operands, step one digit per cycle, load the
  // visible result registers only on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub ? ~cin : cin;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        a_sh  <= a_nxt;
        b_sh  <= b_nxt;
        carry <= dco;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= a_nxt;
          cout <= dco;
          ovf  <= dco ^ dcmsb;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: directed 16-bit vectors, reset abort, handshake
// corners, and an exhaustive 4-bit sweep on DIGIT=1 and DIGIT=4 instances.
module tb_seq_add_sub;
  import seq_add_sub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, DIGIT=4 instance
  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  // 4-bit instances, DIGIT=1 and DIGIT=4, sharing inputs
  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy_d1, done_d1, cout_d1, ovf_d1;
  logic [3:0]  sum_d1;
  logic        busy_d4, done_d4, cout_d4, ovf_d4;
  logic [3:0]  sum_d4;

  seq_add_sub #(.WIDTH(DEF_WIDTH), .DIGIT(DEF_DIGIT)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  seq_add_sub #(.WIDTH(4), .DIGIT(1)) u4_d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy_d1), .done(done_d1), .sum(sum_d1), .cout(cout_d1), .ovf(ovf_d1)
  );

  seq_add_sub #(.WIDTH(4), .DIGIT(4)) u4_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy_d4), .done(done_d4), .sum(sum_d4), .cout(cout_d4), .ovf(ovf_d4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one 16-bit operation and return cycles from accept edge to done.
  task automatic op16(input logic s, input logic [15:0] av, input logic [15:0] bv,
                      input logic c, output int lat);
    sub16 = s; a16 = av; b16 = bv; cin16 = c; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, first_k, k1, k4;
    logic seen;
    logic [4:0] r1, r4;
    logic o1, o4;

    //            sub   a         b         cin   sum       co    ov
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", busy16, 1'b0);
    chk("rst_done", done16, 1'b0);
    chk("rst_sum",  sum16,  16'h0);
    chk("rst_cout", cout16, 1'b0);
    chk("rst_ovf",  ovf16,  1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vecs[i]) begin
      op16(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_sum", i), sum16, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), cout16, vecs[i].co);
      chk($sformatf("vec%0d_ovf", i), ovf16, vecs[i].ov);
    end

    // Second start while busy is ignored
    sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    ndone = 0; first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b0;
      end
      if (k == 2) start16 = 1'b0;
      if (done16) begin
        ndone++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("busy_ignore_pulses", ndone, 1);
    chk("busy_ignore_latency", first_k, 4);
    chk("busy_ignore_sum", sum16, 16'h5556);

    // Start held through done: accepted again on the done cycle
    sub16 = 1'b0; a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = k;
        break;
      end
    end
    chk("held_first_latency", lat, 4);
    chk("held_first_sum", sum16, 16'h0003);
    a16 = 16'h0010; b16 = 16'h0020;
    @(posedge clk); #1;
    start16 = 1'b0;
    chk("held_busy_after_accept", busy16, 1'b1);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = k;
        break;
      end
      chk($sformatf("held_sum_stable_k%0d", k), sum16, 16'h0003);
    end
    chk("held_second_latency", lat, 4);
    chk("held_second_sum", sum16, 16'h0030);

    // Asynchronous reset two cycles into RUN
    sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", busy16, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy16, 1'b0);
    chk("abort_done", done16, 1'b0);
    chk("abort_sum",  sum16,  16'h0);
    chk("abort_cout", cout16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen = 1'b1;
    end
    chk("abort_no_done_after", seen, 1'b0);

    // Exhaustive 4-bit sweep, DIGIT=1 (NDIG=4) and DIGIT=4 (NDIG=1)
    for (int s = 0; s < 2; s++)
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int c = 0; c < 2; c++) begin
            int ra, sa, sb, res;
            logic [4:0] rexp;
            logic oexp;
            sub4 = 1'(s); a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(c); start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            k1 = -1; k4 = -1; r1 = '0; r4 = '0; o1 = 1'b0; o4 = 1'b0;
            for (int k = 1; k <= 6; k++) begin
              @(posedge clk); #1;
              if (done_d1 && k1 < 0) begin k1 = k; r1 = {cout_d1, sum_d1}; o1 = ovf_d1; end
              if (done_d4 && k4 < 0) begin k4 = k; r4 = {cout_d4, sum_d4}; o4 = ovf_d4; end
            end
            ra   = (s != 0) ? av + ((~bv) & 15) + (c ^ 1) : av + bv + c;
            rexp = 5'(ra & 31);
            sa   = (av >= 8) ? av - 16 : av;
            sb   = (bv >= 8) ? bv - 16 : bv;
            res  = (s != 0) ? sa - sb - c : sa + sb + c;
            oexp = (res > 7) || (res < -8);
            chk($sformatf("x_d1_lat s%0d a%0d b%0d c%0d", s, av, bv, c), k1, 4);
            chk($sformatf("x_d1_res s%0d a%0d b%0d c%0d", s, av, bv, c), r1, rexp);
            chk($sformatf("x_d1_ovf s%0d a%0d b%0d c%0d", s, av, bv, c), o1, oexp);
            chk($sformatf("x_d4_lat s%0d a%0d b%0d c%0d", s, av, bv, c), k4, 1);
            chk($sformatf("x_d4_res s%0d a%0d b%0d c%0d", s, av, bv, c), r4, rexp);
            chk($sformatf("x_d4_ovf s%0d a%0d b%0d c%0d", s, av, bv, c), o4, oexp);
          end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
